// File: rtl/truth_table_sweeper_if.sv
// Purpose: bundles the sweeper's control, stimulus and result signals.
// Latency: none, wiring only.
// Backpressure: none; start/abort are single-cycle pulses.
interface truth_table_sweeper_if #(
   parameter int N_IN = 3
);
   logic            start;
   logic            abort;
   logic            dut_out;
   logic [N_IN-1:0] vec_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_cnt;
   logic [N_IN-1:0] first_err_vec;
   logic            first_err_valid;

   // Controller / bench side: issues commands, observes stimulus and results.
   modport master (
      output start, abort, dut_out,
      input  vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );

   // Sweeper side.
   modport slave (
      input  start, abort, dut_out,
      output vec_out, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Purpose: walks all 2**N_IN input vectors, checks dut_out against the EXPECT truth table.
// Latency: each vector held HOLD cycles; done rises 2**N_IN*HOLD edges after the start edge.
// Backpressure: none; start is ignored while busy, abort returns to IDLE.
module truth_table_sweeper #(
   parameter int                  N_IN   = 3,
   parameter int                  HOLD   = 4,
   parameter logic [2**N_IN-1:0]  EXPECT = 8'b1110_1000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   truth_table_sweeper_if.slave       bus
);

   localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t          state, state_n;
   logic [N_IN-1:0] vec_r, vec_n;
   logic [HW-1:0]   hold_r, hold_n;
   logic [N_IN:0]   err_r, err_n;
   logic [N_IN-1:0] fev_r, fev_n;
   logic            fevld_r, fevld_n;
   logic            busy_r, busy_n;
   logic            done_r, done_n;
   logic            pass_r, pass_n;
   logic            mismatch;

   // State and result registers; everything clears asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         vec_r   <= '0;
         hold_r  <= '0;
         err_r   <= '0;
         fev_r   <= '0;
         fevld_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         state   <= state_n;
         vec_r   <= vec_n;
         hold_r  <= hold_n;
         err_r   <= err_n;
         fev_r   <= fev_n;
         fevld_r <= fevld_n;
         busy_r  <= busy_n;
         done_r  <= done_n;
         pass_r  <= pass_n;
      end
   end

   // Next-state and next-output logic; results hold unless a transition updates them.
   always_comb begin
      state_n  = state;
      vec_n    = vec_r;
      hold_n   = hold_r;
      err_n    = err_r;
      fev_n    = fev_r;
      fevld_n  = fevld_r;
      busy_n   = busy_r;
      done_n   = done_r;
      pass_n   = pass_r;
      mismatch = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n = APPLY;
               vec_n   = '0;
               hold_n  = '0;
               err_n   = '0;
               fev_n   = '0;
               fevld_n = 1'b0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
               pass_n  = 1'b0;
            end
         end
         APPLY: begin
            if (bus.abort) begin
               // Error results are deliberately kept so an aborted run can be inspected.
               state_n = IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b0;
               pass_n  = 1'b0;
            end else if (hold_r != HOLD_LAST) begin
               hold_n = hold_r + HW'(1);
            end else begin
               mismatch = (bus.dut_out != EXPECT[vec_r]);
               if (mismatch) begin
                  err_n = err_r + (N_IN+1)'(1);
                  if (!fevld_r) begin
                     fev_n   = vec_r;
                     fevld_n = 1'b1;
                  end
               end
               if (vec_r != {N_IN{1'b1}}) begin
                  vec_n  = vec_r + N_IN'(1);
                  hold_n = '0;
               end else begin
                  // The last sample's mismatch is already folded into err_n.
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  pass_n  = (err_n == '0);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.vec_out         = vec_r;
   assign bus.busy            = busy_r;
   assign bus.done            = done_r;
   assign bus.pass            = pass_r;
   assign bus.err_cnt         = err_r;
   assign bus.first_err_vec   = fev_r;
   assign bus.first_err_valid = fevld_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: directed bench for truth_table_sweeper (default 3-input majority and a 4-input AND, HOLD=1).
// Latency: checks done at 2**N_IN*HOLD edges after the start edge.
// Backpressure: none; start/abort are driven as single-cycle pulses.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst_n;
   logic stuck0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(3)) sw_a ();
   truth_table_sweeper_if #(.N_IN(4)) sw_b ();

   // DUT models: majority (or stuck-at-0) for instance a, AND4 for instance b.
   assign sw_a.dut_out = stuck0 ? 1'b0 :
                         ((sw_a.vec_out[0] & sw_a.vec_out[1]) |
                          (sw_a.vec_out[0] & sw_a.vec_out[2]) |
                          (sw_a.vec_out[1] & sw_a.vec_out[2]));
   assign sw_b.dut_out = &sw_b.vec_out;

   truth_table_sweeper u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw_a.slave)
   );

   truth_table_sweeper #(.N_IN(4), .HOLD(1), .EXPECT(16'h8000)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start_a();
      sw_a.start = 1'b1;
      step(1);
      sw_a.start = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      stuck0      = 1'b0;
      sw_a.start  = 1'b0;
      sw_a.abort  = 1'b0;
      sw_b.start  = 1'b0;
      sw_b.abort  = 1'b0;
      step(2);
      check("rst_vec",   32'(sw_a.vec_out), 0);
      check("rst_busy",  32'(sw_a.busy), 0);
      check("rst_done",  32'(sw_a.done), 0);
      check("rst_pass",  32'(sw_a.pass), 0);
      check("rst_err",   32'(sw_a.err_cnt), 0);
      check("rst_fev",   32'(sw_a.first_err_vec), 0);
      check("rst_fevld", 32'(sw_a.first_err_valid), 0);
      rst_n = 1'b1;
      step(2);

      // Majority DUT, clean sweep: vec steps every 4 cycles, done at edge 32.
      pulse_start_a();
      check("maj_busy0", 32'(sw_a.busy), 1);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("maj_vec%0d", k), 32'(sw_a.vec_out), 32'(k));
         if (k < 7) step(4);
      end
      check("maj_done_e28", 32'(sw_a.done), 0);
      step(4);
      check("maj_done",  32'(sw_a.done), 1);
      check("maj_pass",  32'(sw_a.pass), 1);
      check("maj_busy",  32'(sw_a.busy), 0);
      check("maj_err",   32'(sw_a.err_cnt), 0);
      check("maj_fevld", 32'(sw_a.first_err_valid), 0);
      check("maj_vec_hold", 32'(sw_a.vec_out), 7);
      step(3);
      check("done_frozen", 32'(sw_a.done), 1);

      // Stuck-at-0 DUT, restart from DONE: mismatches at 3,5,6,7.
      stuck0 = 1'b1;
      pulse_start_a();
      check("sa0_clr_err",  32'(sw_a.err_cnt), 0);
      check("sa0_clr_done", 32'(sw_a.done), 0);
      check("sa0_busy",     32'(sw_a.busy), 1);
      step(32);
      check("sa0_done",  32'(sw_a.done), 1);
      check("sa0_err",   32'(sw_a.err_cnt), 4);
      check("sa0_fev",   32'(sw_a.first_err_vec), 3);
      check("sa0_fevld", 32'(sw_a.first_err_valid), 1);
      check("sa0_pass",  32'(sw_a.pass), 0);

      // Restart after failure with a correct DUT: results clear at the start edge.
      stuck0 = 1'b0;
      pulse_start_a();
      check("re_err",   32'(sw_a.err_cnt), 0);
      check("re_fevld", 32'(sw_a.first_err_valid), 0);
      check("re_done",  32'(sw_a.done), 0);
      step(31);
      check("re_done_e31", 32'(sw_a.done), 0);
      step(1);
      check("re_done_e32", 32'(sw_a.done), 1);
      check("re_pass",     32'(sw_a.pass), 1);
      check("re_err_end",  32'(sw_a.err_cnt), 0);

      // Stuck-at-0: start re-pulsed at vec 2 is ignored, abort at vec 4 keeps results.
      stuck0 = 1'b1;
      pulse_start_a();
      step(8);
      check("ign_vec2", 32'(sw_a.vec_out), 2);
      pulse_start_a();
      check("ign_vec2b", 32'(sw_a.vec_out), 2);
      check("ign_busy",  32'(sw_a.busy), 1);
      step(7);
      check("ign_vec4",  32'(sw_a.vec_out), 4);
      check("ign_err1",  32'(sw_a.err_cnt), 1);
      sw_a.abort = 1'b1;
      step(1);
      sw_a.abort = 1'b0;
      check("ab_busy",  32'(sw_a.busy), 0);
      check("ab_done",  32'(sw_a.done), 0);
      check("ab_pass",  32'(sw_a.pass), 0);
      check("ab_err",   32'(sw_a.err_cnt), 1);
      check("ab_fev",   32'(sw_a.first_err_vec), 3);
      check("ab_fevld", 32'(sw_a.first_err_valid), 1);
      step(8);
      check("ab_idle_busy", 32'(sw_a.busy), 0);
      check("ab_idle_done", 32'(sw_a.done), 0);

      // Abort and start together while sweeping: abort wins.
      pulse_start_a();
      step(2);
      sw_a.start = 1'b1;
      sw_a.abort = 1'b1;
      step(1);
      sw_a.start = 1'b0;
      sw_a.abort = 1'b0;
      check("abst_busy", 32'(sw_a.busy), 0);
      check("abst_done", 32'(sw_a.done), 0);
      step(4);
      check("abst_idle", 32'(sw_a.busy), 0);

      // Asynchronous reset mid-sweep at vec 5 (err_cnt already 1 from vec 3).
      pulse_start_a();
      step(20);
      check("rs_vec5", 32'(sw_a.vec_out), 5);
      check("rs_err1", 32'(sw_a.err_cnt), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rs_vec",   32'(sw_a.vec_out), 0);
      check("rs_busy",  32'(sw_a.busy), 0);
      check("rs_err",   32'(sw_a.err_cnt), 0);
      check("rs_fevld", 32'(sw_a.first_err_valid), 0);
      check("rs_fev",   32'(sw_a.first_err_vec), 0);
      step(2);
      rst_n = 1'b1;
      step(10);
      check("rs_no_resume_vec",  32'(sw_a.vec_out), 0);
      check("rs_no_resume_busy", 32'(sw_a.busy), 0);
      check("rs_no_resume_done", 32'(sw_a.done), 0);

      // AND4, HOLD=1: vec increments every cycle, done at edge 16.
      sw_b.start = 1'b1;
      step(1);
      sw_b.start = 1'b0;
      check("b_busy", 32'(sw_b.busy), 1);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("b_vec%0d", k), 32'(sw_b.vec_out), 32'(k));
         if (k < 15) step(1);
      end
      check("b_done_e15", 32'(sw_b.done), 0);
      step(1);
      check("b_done", 32'(sw_b.done), 1);
      check("b_pass", 32'(sw_b.pass), 1);
      check("b_err",  32'(sw_b.err_cnt), 0);
      check("b_busy_end", 32'(sw_b.busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Parametrised, synthesisable exhaustive-stimulus engine for small combinational blocks. Walks every input combination of an N_IN-input function and holds each vector for HOLD cycles. Samples the DUT output and compares it against a parameterised truth table, reporting error count, first failing vector and pass/fail. It is the successor to free-running toggle stimulus: it is clocked, restartable and self-checking, and sits between a combinational DUT and board LEDs or a bench.

Parameters:
N_IN, 3, number of DUT inputs (1..8); sweep length is 2**N_IN vectors
HOLD, 4, clock cycles each vector is held (>=1); the DUT is sampled in the last hold cycle
EXPECT, 8'b1110_1000, expected DUT output; bit k is the expected value for vector k; width 2**N_IN (default = 3-input majority)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; starts a sweep from IDLE or DONE, ignored while busy
abort  input  1  pulse; ends a sweep in progress and returns to IDLE
dut_out  input  1  DUT response to vec_out
vec_out  output  N_IN  stimulus to the DUT; bit 0 toggles fastest
busy  output  1  high while sweeping
done  output  1  high in DONE until next start or reset
pass  output  1  valid when done: 1 iff err_cnt==0
err_cnt  output  N_IN+1  number of mismatching vectors (max 2**N_IN, no saturation needed)
first_err_vec  output  N_IN  first vector that mismatched
first_err_valid  output  1  first_err_vec holds a captured value

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0; hold counter 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, APPLY, DONE.
- IDLE: start=1 -> APPLY. Same edge: vec_out=0, hold_cnt=0, err_cnt=0, first_err_valid=0, first_err_vec=0, busy=1, done=0, pass=0.
- APPLY, hold_cnt < HOLD-1: hold_cnt++. vec_out is stable.
- APPLY, hold_cnt == HOLD-1 (sample edge): compare dut_out with EXPECT[vec_out].
  - On mismatch: err_cnt++. If first_err_valid==0, capture first_err_vec=vec_out and set first_err_valid=1.
  - If vec_out != 2**N_IN-1: vec_out++ and hold_cnt=0.
  - Else: go to DONE. busy=0, done=1, pass=(final err_cnt==0), counting any mismatch on this last sample. vec_out keeps its last value.
- HOLD=1: sample every cycle; vec_out advances every cycle.
- Timing: start sampled at edge 0 -> busy=1 after edge 0 -> done=1 after edge 2**N_IN*HOLD. Default = edge 32.
- DONE: outputs are frozen. start=1 -> behaves exactly as start from IDLE, clearing all results.
- start while in APPLY: ignored, with no effect on the counters.
- abort while in APPLY: -> IDLE, busy=0, done=0, pass=0. err_cnt and first_err_* keep their values, for debug.
- abort and start on the same edge: abort wins.
- abort in IDLE or DONE: ignored.
- rst_n asserted mid-sweep: everything clears immediately. No sweep resumes after release until a new start.
- Comparison uses dut_out as sampled at the clock edge. The DUT settle time must fit within HOLD cycles; the block does not check this.

Test Plan:
- Defaults (N_IN=3, HOLD=4), DUT = majority model, start pulse at edge 0 -> vec_out steps 0..7 every 4 cycles; done=1 and pass=1 at edge 32; err_cnt=0; first_err_valid=0.
- Defaults, DUT stuck-at-0 -> done at edge 32; err_cnt=4; first_err_vec=3'b011; first_err_valid=1; pass=0.
- Defaults, rst_n pulsed low asynchronously while vec_out=5 -> all outputs 0 immediately; no further vec_out activity until the next start.
- start re-pulsed at vec_out=2, then abort at vec_out=4 with the stuck-at-0 DUT -> the second start has no effect; after abort: state IDLE, busy=0, done=0, err_cnt=1, first_err_vec=3.
- N_IN=4, HOLD=1, EXPECT=16'h8000 (AND4), DUT = AND4 -> vec_out increments every cycle 0..15; done=1 at edge 16; pass=1.
- After a failing sweep (err_cnt=4), start from DONE with a correct DUT -> err_cnt clears to 0 at the start edge; done at +32 cycles; pass=1; first_err_valid=0.
